// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the CPU-side RAM port between NUM_REQ requesters.
// Define ARB_LOCK_EN to add the per-requester burst lock input.
module ram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_we,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
`ifdef ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]        lock
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      sel;
  logic               found;
  logic               hold;
  logic               xfer;
  int                 idx;
  logic [NUM_REQ-1:0] pipe [RD_LATENCY+1];

`ifdef ARB_LOCK_EN
  logic [PW-1:0] own;
  logic          own_vld;
`endif

  always_comb begin
    gnt   = '0;
    sel   = '0;
    found = 1'b0;
    hold  = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
`ifdef ARB_LOCK_EN
    // the last owner keeps the port while it holds lock with req
    if (own_vld && req[own] && lock[own]) begin
      found = 1'b1;
      sel   = own;
      hold  = 1'b1;
    end
`endif
    if (found && resetN)
      gnt[sel] = 1'b1;
  end

  assign xfer = |gnt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      ptr       <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      for (int k = 0; k <= RD_LATENCY; k++)
        pipe[k] <= '0;
`ifdef ARB_LOCK_EN
      own       <= '0;
      own_vld   <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        ram_addr  <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
        ram_wdata <= req_wdata[int'(sel)*DATA_W +: DATA_W];
        ram_we    <= req_we[sel];
        if (!hold)
          ptr <= (sel == PW'(NUM_REQ-1)) ? '0 : sel + PW'(1);
`ifdef ARB_LOCK_EN
        own     <= sel;
        own_vld <= 1'b1;
`endif
      end else begin
        ram_we <= 1'b0;
      end
      // read tags ride alongside the RAM latency; writes leave a bubble
      pipe[0] <= (xfer && !req_we[sel]) ? gnt : '0;
      for (int k = 1; k <= RD_LATENCY; k++)
        pipe[k] <= pipe[k-1];
      rvalid <= pipe[RD_LATENCY];
      if (|pipe[RD_LATENCY])
        rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a scoreboard on the read-return path.
// Lock steps are built only when ARB_LOCK_EN is defined.
module tb_ram_port_arbiter;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  req, req_we, gnt, rvalid;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [15:0] rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
`ifdef ARB_LOCK_EN
  logic [1:0]  lock;
`endif

  ram_port_arbiter #(
    .NUM_REQ(2), .ADDR_W(8), .DATA_W(16), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .resetN(resetN), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_LOCK_EN
    ,
    .lock(lock)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [15:0] exp_mem [256];
  logic [15:0] rpipe [L];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rpipe[0] <= mem[ram_addr];
    for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
  end
  assign ram_rdata = rpipe[L-1];

  typedef struct {
    int          due;
    logic [1:0]  tag;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit nopush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rvalid", 32'(rvalid), 32'(q[0].tag));
      chk("rdata", 32'(rdata), 32'(q[0].data));
      void'(q.pop_front());
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'd0);
    end
  end

  task automatic drive(input int i, input logic r, input logic w,
                       input logic [7:0] a, input logic [15:0] d);
    req[i]              = r;
    req_we[i]           = w;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic tick(input logic [1:0] eg);
    logic [7:0] a;
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (!nopush)
      for (int i = 0; i < 2; i++)
        if (eg[i]) begin
          a = req_addr[i*8 +: 8];
          if (req_we[i])
            exp_mem[a] = req_wdata[i*16 +: 16];
          else
            q.push_back('{cyc + 2 + L, 2'(1 << i), exp_mem[a]});
        end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 37 + 5);
      exp_mem[i] = 16'(i * 37 + 5);
    end
    resetN = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    drive(0, 1, 0, 8'h01, 16'h0);
    drive(1, 1, 0, 8'h02, 16'h0);
    @(negedge clk);
    tick(2'b00);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    tick(2'b00);

    // release with both requesting: fair alternation
    resetN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 8'(8'h20 + k), 16'h0);
      drive(1, 1, 0, 8'(8'h40 + k), 16'h0);
      tick((k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // write then read of the same address
    drive(0, 1, 1, 8'h03, 16'hBEEF);
    drive(1, 0, 0, 8'h00, 16'h0);
    tick(2'b01);
    drive(0, 0, 0, 8'h00, 16'h0);
    drive(1, 1, 0, 8'h03, 16'h0);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h03);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    tick(2'b10);

    // write to 0x10 then idle; address and pointer must hold
    drive(0, 1, 1, 8'h10, 16'h1234);
    drive(1, 0, 0, 8'h00, 16'h0);
    tick(2'b01);
    drive(0, 0, 0, 8'h00, 16'h0);
    for (int k = 0; k < 5; k++) begin
      chk("idle_ram_addr", 32'(ram_addr), 32'h10);
      chk("idle_ram_we", 32'(ram_we), (k == 0) ? 32'd1 : 32'd0);
      tick(2'b00);
    end
    drive(0, 1, 0, 8'h10, 16'h0);
    drive(1, 1, 0, 8'h11, 16'h0);
    tick(2'b10);
    drive(1, 0, 0, 8'h00, 16'h0);
    tick(2'b01);
    drive(0, 0, 0, 8'h00, 16'h0);
    for (int k = 0; k < 4; k++) tick(2'b00);

    // reset right after a read grant drops the read
    drive(0, 1, 0, 8'h05, 16'h0);
    nopush = 1'b1;
    tick(2'b01);
    nopush = 1'b0;
    resetN = 1'b0;
    drive(0, 0, 0, 8'h00, 16'h0);
    tick(2'b00);
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) tick(2'b00);
    drive(0, 1, 0, 8'h06, 16'h0);
    drive(1, 1, 0, 8'h07, 16'h0);
    tick(2'b01);

`ifdef ARB_LOCK_EN
    // R1 takes ownership and locks for four grants
    lock = 2'b10;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 8'(8'h50 + k), 16'h0);
      tick(2'b10);
    end
    lock = 2'b00;
    tick(2'b01);
`endif

    req = '0;
    for (int k = 0; k < L + 4; k++) tick(2'b00);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
